mem_alu_param: RTL and testbench
================================

MEM_ALU_PARAM -- requirements
Module: mem_alu_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each storage word.
REQ-002 SHALL have parameter DEPTH, default 4: number of storage words, power of two, >=2; ADDR_W = $clog2(DEPTH).
REQ-003 SHALL have parameter RD_LAT, default 2: read latency in cycles, >=1.
REQ-004 SHALL have port clk  in  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port enable  in  1  memory access request.
REQ-007 SHALL have port rd_wr  in  1  1 = read, 0 = write, qualified by enable.
REQ-008 SHALL have port addr  in  ADDR_W  access address.
REQ-009 SHALL have port wr_data  in  DATA_W  write data.
REQ-010 SHALL have port rd_data  out  DATA_W  read data.
REQ-011 SHALL have port rd_valid  out  1  one-cycle pulse marking rd_data update.
REQ-012 SHALL have port op_start  in  1  compute request.
REQ-013 SHALL have port op_code  in  3  operation select.
REQ-014 SHALL have ports src_a and src_b  in  ADDR_W  each; operand addresses.
REQ-015 SHALL have port res_out  out  2*DATA_W  ALU result.
REQ-016 SHALL have port res_valid  out  1  one-cycle result pulse.
REQ-017 SHALL have port busy  out  1  compute in progress.
REQ-018 SHALL have port err  out  1  one-cycle error pulse.

Function
REQ-019 Write: enable=1, rd_wr=0, busy=0 at an edge SHALL update mem[addr] with wr_data at that edge.
REQ-020 Write attempted with busy=1 SHALL be dropped, with err pulsed the following cycle.
REQ-021 Read: enable=1, rd_wr=1 at edge N SHALL present mem[addr] (value at edge N) on rd_data with rd_valid=1 after edge N+RD_LAT; reads are accepted every cycle, pipelined, and allowed while busy.
REQ-022 rd_data SHALL hold its last value between rd_valid pulses.
REQ-023 FSM states SHALL be IDLE, LOAD, EXEC, DONE.
REQ-024 IDLE->LOAD SHALL occur on op_start=1; the FSM latches op_code, src_a and src_b; op_start outside IDLE SHALL be ignored without error.
REQ-025 LOAD SHALL latch operands A=mem[src_a] and B=mem[src_b]; a write accepted at the op_start edge SHALL be visible to LOAD.
REQ-026 LOAD->EXEC->DONE->IDLE SHALL be unconditional, one cycle each.
REQ-027 busy SHALL be 1 in LOAD, EXEC and DONE.
REQ-028 res_valid SHALL be 1 only in DONE, three cycles after the op_start edge.
REQ-029 res_out SHALL update entering DONE and hold until the next DONE.
REQ-030 Op codes SHALL be: 0 ADD (zero-extended, carry in bit DATA_W); 1 SUB (A-B two's complement, sign-extended to 2*DATA_W); 2 MUL (unsigned full product); 3 AND; 4 OR; 5 XOR (3-5 zero-extended).
REQ-031 Op codes 6-7 SHALL give res_out=0 with res_valid=1 and err=1 in DONE.
REQ-032 Simultaneous write error and illegal-op error SHALL produce a single err pulse.

Reset
REQ-033 rst=0 at an edge SHALL force: FSM IDLE, all mem words 0, rd_data 0, rd_valid 0, res_out 0, res_valid 0, busy 0, err 0, read pipeline flushed.
REQ-034 Reset mid-operation SHALL abort it; no res_valid for the aborted operation, and no rd_valid for reads in flight.
REQ-035 Inputs SHALL be ignored while rst=0.

Structure
REQ-036 Package mem_alu_pkg SHALL hold the op_e enum (codes 0-5), the state_e enum and the default parameter constants.
REQ-037 Combinational sub-module alu_unit (A, B, op -> result, illegal flag) SHALL hold the arithmetic; mem_alu_param holds the storage, read pipeline and FSM.

Verification (DATA_W=8, DEPTH=4, RD_LAT=2)
REQ-038 Reset, then read addr 2 -> rd_data=0x00 with rd_valid two cycles later.
REQ-039 Write 0xFF->0 and 0x02->1, then MUL src_a=0 src_b=1 -> res_out=0x01FE, res_valid exactly 3 cycles after op_start.
REQ-040 Write 0x01->2 and 0x02->3, then SUB src_a=2 src_b=3 -> res_out=0xFFFF.
REQ-041 Start ADD, write 0x55->0 during LOAD -> err pulse next cycle, read of addr 0 returns the old value.
REQ-042 rst=0 during EXEC -> busy=0 next cycle, no res_valid, res_out=0.
REQ-043 op_code=7 -> res_valid with res_out=0x0000 and err=1 in the same cycle.

Source files
------------

// File: rtl/mem_alu_pkg.sv
// Shared types and default sizing for the memory-backed ALU block.
// The op and state encodings are fixed here so the RTL and the bench agree on them.
package mem_alu_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned RD_LAT_DEF = 2;

    // Codes 6 and 7 are left unassigned and are decoded as illegal.
    typedef enum logic [2:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpMul = 3'd2,
        OpAnd = 3'd3,
        OpOr  = 3'd4,
        OpXor = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StExec = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/mem_alu_param_if.sv
// Access and compute bus for mem_alu_param.
// The master side issues memory and compute requests; the slave side is the block itself.
interface mem_alu_param_if import mem_alu_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic                enable;
    logic                rd_wr;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid;
    logic                op_start;
    logic [2:0]          op_code;
    logic [ADDR_W-1:0]   src_a;
    logic [ADDR_W-1:0]   src_b;
    logic [2*DATA_W-1:0] res_out;
    logic                res_valid;
    logic                busy;
    logic                err;

    modport master (
        output enable, rd_wr, addr, wr_data, op_start, op_code, src_a, src_b,
        input  rd_data, rd_valid, res_out, res_valid, busy, err
    );

    modport slave (
        input  enable, rd_wr, addr, wr_data, op_start, op_code, src_a, src_b,
        output rd_data, rd_valid, res_out, res_valid, busy, err
    );

endinterface

// File: rtl/alu_unit.sv
// Purely combinational arithmetic core: two DATA_W operands in, a 2*DATA_W result out.
// Unassigned op codes return zero and raise the illegal flag.
module alu_unit import mem_alu_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [2:0]          op,
    output logic [2*DATA_W-1:0] result,
    output logic                illegal
);

    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [DATA_W-1:0]   diff;

    assign a_ext = {{DATA_W{1'b0}}, a};
    assign b_ext = {{DATA_W{1'b0}}, b};
    // Subtraction wraps at DATA_W and is then sign-extended.
    assign diff  = a - b;

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OpAdd:   result = a_ext + b_ext;
            OpSub:   result = {{DATA_W{diff[DATA_W-1]}}, diff};
            OpMul:   result = a_ext * b_ext;
            OpAnd:   result = a_ext & b_ext;
            OpOr:    result = a_ext | b_ext;
            OpXor:   result = a_ext ^ b_ext;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_alu_param.sv
// Small register-file memory with a pipelined read port and a four-state compute FSM
// that fetches two words, runs them through alu_unit and reports the result.
module mem_alu_param import mem_alu_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    mem_alu_param_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]   mem_q [DEPTH];

    state_e              state_q, state_d;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   src_a_q, src_b_q;
    logic [DATA_W-1:0]   opa_q, opb_q;
    logic [2*DATA_W-1:0] res_q;
    logic [2*DATA_W-1:0] alu_res;
    logic                alu_illegal;
    logic                illegal_q;
    logic                wr_err_q;

    // Stage 0 captures at the request edge; stage RD_LAT is the visible output.
    logic [RD_LAT:0]     pipe_vld_q;
    logic [DATA_W-1:0]   pipe_data_q [RD_LAT+1];

    logic                busy;
    logic                wr_req;
    logic                wr_ok;
    logic                rd_req;
    logic                in_done;

    assign busy    = (state_q != StIdle);
    assign in_done = (state_q == StDone);
    assign wr_req  = bus.enable & ~bus.rd_wr;
    assign wr_ok   = wr_req & ~busy;
    assign rd_req  = bus.enable & bus.rd_wr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[bus.addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i <= int'(RD_LAT); i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q <= {pipe_vld_q[RD_LAT-1:0], rd_req};
            if (rd_req) begin
                pipe_data_q[0] <= mem_q[bus.addr];
            end
            // Data only advances behind a valid, so the last stage holds between pulses.
            for (int i = 1; i <= int'(RD_LAT); i++) begin
                if (pipe_vld_q[i-1]) begin
                    pipe_data_q[i] <= pipe_data_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.op_start) state_d = StLoad;
            StLoad:  state_d = StExec;
            StExec:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q      <= '0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            if (state_q == StIdle && bus.op_start) begin
                op_q    <= bus.op_code;
                src_a_q <= bus.src_a;
                src_b_q <= bus.src_b;
            end
            // Reads in LOAD see any write accepted at the op_start edge.
            if (state_q == StLoad) begin
                opa_q <= mem_q[src_a_q];
                opb_q <= mem_q[src_b_q];
            end
            if (state_q == StExec) begin
                res_q     <= alu_res;
                illegal_q <= alu_illegal;
            end
            wr_err_q <= wr_req & busy;
        end
    end

    alu_unit #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a       (opa_q),
        .b       (opb_q),
        .op      (op_q),
        .result  (alu_res),
        .illegal (alu_illegal)
    );

    assign bus.rd_data   = pipe_data_q[RD_LAT];
    assign bus.rd_valid  = pipe_vld_q[RD_LAT];
    assign bus.res_out   = res_q;
    assign bus.res_valid = in_done;
    assign bus.busy      = busy;
    // OR-merge so a dropped write and an illegal op landing together give one pulse.
    assign bus.err       = wr_err_q | (in_done & illegal_q);

endmodule

// File: tb/tb_mem_alu_param.sv
// Directed bench for mem_alu_param at DATA_W=8, DEPTH=4, RD_LAT=2.
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
module tb_mem_alu_param import mem_alu_pkg::*;;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_alu_param_if #(.DATA_W(8), .DEPTH(4)) bus ();

    mem_alu_param #(
        .DATA_W (8),
        .DEPTH  (4),
        .RD_LAT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.enable   = 1'b0;
        bus.rd_wr    = 1'b0;
        bus.addr     = '0;
        bus.wr_data  = '0;
        bus.op_start = 1'b0;
        bus.op_code  = '0;
        bus.src_a    = '0;
        bus.src_b    = '0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        bus.enable  = 1'b1;
        bus.rd_wr   = 1'b0;
        bus.addr    = a;
        bus.wr_data = d;
        tick();
        bus.enable  = 1'b0;
    endtask

    // Leaves the FSM in LOAD (one edge past op_start).
    task automatic start_op(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb);
        bus.op_start = 1'b1;
        bus.op_code  = op;
        bus.src_a    = sa;
        bus.src_b    = sb;
        tick();
        bus.op_start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        // Write during reset must be ignored.
        bus.enable  = 1'b1;
        bus.addr    = 2'd2;
        bus.wr_data = 8'h77;
        tick();
        tick();
        bus.enable = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_tests++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
        n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err); end
        n_tests++; if (bus.res_out !== 16'h0000) begin n_fail++; $display("FAIL reset_res_out got %h want 0000", bus.res_out); end
        n_tests++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", bus.rd_data); end
        rst = 1'b1;
    endtask

    task automatic test_read_after_reset();
        bus.enable = 1'b1;
        bus.rd_wr  = 1'b1;
        bus.addr   = 2'd2;
        tick();
        bus.enable = 1'b0;
        n_tests++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd0_early1 got %b want 0", bus.rd_valid); end
        tick();
        n_tests++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd0_early2 got %b want 0", bus.rd_valid); end
        tick();
        n_tests++; if ({bus.rd_valid, bus.rd_data} !== 9'h100) begin n_fail++; $display("FAIL rd0_data got %b/%h want 1/00", bus.rd_valid, bus.rd_data); end
        tick();
        n_tests++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd0_pulse got %b want 0", bus.rd_valid); end
    endtask

    task automatic test_back_to_back_reads();
        do_write(2'd2, 8'hA5);
        do_write(2'd3, 8'h3C);
        bus.enable = 1'b1;
        bus.rd_wr  = 1'b1;
        bus.addr   = 2'd2;
        tick();
        bus.addr   = 2'd3;
        tick();
        bus.enable = 1'b0;
        n_tests++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early got %b want 0", bus.rd_valid); end
        tick();
        n_tests++; if ({bus.rd_valid, bus.rd_data} !== 9'h1A5) begin n_fail++; $display("FAIL b2b_first got %b/%h want 1/a5", bus.rd_valid, bus.rd_data); end
        tick();
        n_tests++; if ({bus.rd_valid, bus.rd_data} !== 9'h13C) begin n_fail++; $display("FAIL b2b_second got %b/%h want 1/3c", bus.rd_valid, bus.rd_data); end
        tick();
        n_tests++; if ({bus.rd_valid, bus.rd_data} !== 9'h03C) begin n_fail++; $display("FAIL b2b_hold got %b/%h want 0/3c", bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_mul();
        do_write(2'd0, 8'hFF);
        do_write(2'd1, 8'h02);
        start_op(OpMul, 2'd0, 2'd1);
        n_tests++; if ({bus.busy, bus.res_valid} !== 2'b10) begin n_fail++; $display("FAIL mul_load got busy=%b rv=%b want 1/0", bus.busy, bus.res_valid); end
        tick();
        n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL mul_exec_rv got %b want 0", bus.res_valid); end
        tick();
        n_tests++; if ({bus.res_valid, bus.res_out} !== 17'h101FE) begin n_fail++; $display("FAIL mul_done got %b/%h want 1/01fe", bus.res_valid, bus.res_out); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL mul_err got %b want 0", bus.err); end
        tick();
        n_tests++; if ({bus.res_valid, bus.busy, bus.res_out} !== 18'h001FE) begin n_fail++; $display("FAIL mul_after got rv=%b busy=%b %h want 0/0/01fe", bus.res_valid, bus.busy, bus.res_out); end
    endtask

    task automatic test_sub();
        do_write(2'd2, 8'h01);
        do_write(2'd3, 8'h02);
        start_op(OpSub, 2'd2, 2'd3);
        tick();
        tick();
        n_tests++; if ({bus.res_valid, bus.res_out} !== 17'h1FFFF) begin n_fail++; $display("FAIL sub_neg got %b/%h want 1/ffff", bus.res_valid, bus.res_out); end
        tick();
    endtask

    // mem = {FF, 02, 01, 02}
    task automatic test_ops();
        logic [2:0]  ops [7] = '{OpAdd, OpAnd, OpOr, OpXor, OpSub, OpSub, OpMul};
        logic [1:0]  sa  [7] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd3, 2'd0};
        logic [1:0]  sb  [7] = '{2'd1, 2'd1, 2'd3, 2'd1, 2'd1, 2'd2, 2'd0};
        logic [15:0] exp [7] = '{16'h0101, 16'h0002, 16'h0003, 16'h00FD, 16'hFFFD, 16'h0001,
                                 16'hFE01};
        for (int i = 0; i < 7; i++) begin
            start_op(ops[i], sa[i], sb[i]);
            tick();
            tick();
            n_tests++;
            if ({bus.res_valid, bus.res_out} !== {1'b1, exp[i]}) begin
                n_fail++;
                $display("FAIL ops[%0d] op=%0d got %b/%h want 1/%h", i, ops[i], bus.res_valid,
                         bus.res_out, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_write_at_start();
        bus.enable   = 1'b1;
        bus.rd_wr    = 1'b0;
        bus.addr     = 2'd1;
        bus.wr_data  = 8'h10;
        start_op(OpAdd, 2'd0, 2'd1);
        bus.enable = 1'b0;
        tick();
        tick();
        n_tests++; if ({bus.res_valid, bus.res_out} !== 17'h1010F) begin n_fail++; $display("FAIL wr_at_start got %b/%h want 1/010f", bus.res_valid, bus.res_out); end
        tick();
    endtask

    task automatic test_write_busy();
        start_op(OpAdd, 2'd0, 2'd1);
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL wbusy_pre got %b want 0", bus.err); end
        bus.enable  = 1'b1;
        bus.rd_wr   = 1'b0;
        bus.addr    = 2'd0;
        bus.wr_data = 8'h55;
        tick();
        bus.enable = 1'b0;
        n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL wbusy_err got %b want 1", bus.err); end
        tick();
        n_tests++; if ({bus.err, bus.res_valid, bus.res_out} !== 18'h1010F) begin n_fail++; $display("FAIL wbusy_done got err=%b rv=%b %h want 0/1/010f", bus.err, bus.res_valid, bus.res_out); end
        tick();
        bus.enable = 1'b1;
        bus.rd_wr  = 1'b1;
        bus.addr   = 2'd0;
        tick();
        bus.enable = 1'b0;
        tick();
        tick();
        n_tests++; if ({bus.rd_valid, bus.rd_data} !== 9'h1FF) begin n_fail++; $display("FAIL wbusy_old got %b/%h want 1/ff", bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_illegal();
        logic [2:0] codes [2] = '{3'd7, 3'd6};
        for (int i = 0; i < 2; i++) begin
            start_op(codes[i], 2'd0, 2'd1);
            tick();
            tick();
            n_tests++;
            if ({bus.res_valid, bus.err, bus.res_out} !== 18'h30000) begin
                n_fail++;
                $display("FAIL illegal_op%0d got rv=%b err=%b %h want 1/1/0000", codes[i],
                         bus.res_valid, bus.err, bus.res_out);
            end
            tick();
            n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_end%0d got %b want 0", codes[i], bus.err); end
        end
    endtask

    task automatic test_simul_err();
        start_op(3'd6, 2'd0, 2'd1);
        tick();
        bus.enable  = 1'b1;
        bus.rd_wr   = 1'b0;
        bus.addr    = 2'd1;
        bus.wr_data = 8'h33;
        tick();
        bus.enable = 1'b0;
        n_tests++; if ({bus.err, bus.res_valid} !== 2'b11) begin n_fail++; $display("FAIL simul_err got err=%b rv=%b want 1/1", bus.err, bus.res_valid); end
        tick();
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL simul_single got %b want 0", bus.err); end
    endtask

    task automatic test_op_start_busy();
        start_op(OpXor, 2'd0, 2'd1);
        bus.op_start = 1'b1;
        bus.op_code  = OpAnd;
        tick();
        tick();
        bus.op_start = 1'b0;
        n_tests++; if ({bus.res_valid, bus.err, bus.res_out} !== 18'h200EF) begin n_fail++; $display("FAIL busy_start got rv=%b err=%b %h want 1/0/00ef", bus.res_valid, bus.err, bus.res_out); end
        tick();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle got %b want 0", bus.busy); end
    endtask

    task automatic test_abort();
        start_op(OpMul, 2'd0, 2'd1);
        bus.enable = 1'b1;
        bus.rd_wr  = 1'b1;
        bus.addr   = 2'd0;
        tick();
        bus.enable = 1'b0;
        rst = 1'b0;
        tick();
        n_tests++; if ({bus.busy, bus.res_valid, bus.err} !== 3'b000) begin n_fail++; $display("FAIL abort_flags got busy=%b rv=%b err=%b want 0/0/0", bus.busy, bus.res_valid, bus.err); end
        n_tests++; if (bus.res_out !== 16'h0000) begin n_fail++; $display("FAIL abort_res got %h want 0000", bus.res_out); end
        rst = 1'b1;
        tick();
        n_tests++; if ({bus.rd_valid, bus.res_valid} !== 2'b00) begin n_fail++; $display("FAIL abort_flush got rdv=%b rv=%b want 0/0", bus.rd_valid, bus.res_valid); end
        tick();
        n_tests++; if ({bus.rd_valid, bus.res_valid, bus.busy} !== 3'b000) begin n_fail++; $display("FAIL abort_late got rdv=%b rv=%b busy=%b want 0/0/0", bus.rd_valid, bus.res_valid, bus.busy); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_read_after_reset();
        test_back_to_back_reads();
        test_mul();
        test_sub();
        test_ops();
        test_write_at_start();
        test_write_busy();
        test_illegal();
        test_simul_err();
        test_op_start_busy();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
